// File: rtl/retire_sb.sv
// Retire stage with tag-ordered commit, exception/interrupt arbitration and a
// small in-order store buffer that drains to memory over a req/gnt handshake.
module retire_sb #(
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             we_i,
    input  logic             jump_i,
    input  logic [31:0]      result0_i,
    input  logic [31:0]      result1_i,
    input  logic [3:0]       we_mem_i,
    input  logic             load_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      load_data_i,
    input  logic             illegal_i,
    input  logic             ecall_i,
    input  logic             ebreak_i,
    input  logic             mret_i,
    input  logic             irq_pending_i,
    output logic             reg_we_o,
    output logic [31:0]      wr_data_o,
    output logic             jump_o,
    output logic [31:0]      new_pc_o,
    output logic [TAG_W-1:0] curr_tag_o,
    output logic             raise_exc_o,
    output logic [3:0]       exc_code_o,
    output logic             mret_o,
    output logic             irq_ack_o,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_gnt_i,
    output logic             sb_empty_o
);

    localparam int unsigned PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

    logic [TAG_W-1:0] curr_tag;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      addr_mem [SB_DEPTH];
    logic [31:0]      data_mem [SB_DEPTH];
    logic [3:0]       be_mem   [SB_DEPTH];

    logic        full;
    logic        empty;
    logic        tag_match;
    logic        is_store;
    logic        live;
    logic        push;
    logic        pop;
    logic        head_vis;
    logic        tag_inc;
    logic [31:0] load_shift;
    logic [31:0] load_ext;

    assign full      = (count == CNT_W'(SB_DEPTH));
    assign empty     = (count == '0);
    assign tag_match = valid_i & (tag_i == curr_tag);
    assign is_store  = |we_mem_i;
    // Full buffer holds the store even if the head is granted this cycle.
    assign stall_o   = tag_match & is_store & full;
    assign live      = tag_match & ~stall_o;

    always_comb begin
        exc_code_o = 4'd0;
        if (live) begin
            if (illegal_i)     exc_code_o = 4'd2;
            else if (ecall_i)  exc_code_o = 4'd11;
            else if (ebreak_i) exc_code_o = 4'd3;
        end
    end

    assign raise_exc_o = live & (illegal_i | ecall_i | ebreak_i);
    assign reg_we_o    = live & we_i & ~raise_exc_o;
    assign jump_o      = live & jump_i & ~raise_exc_o;
    assign new_pc_o    = jump_o ? result1_i : 32'd0;
    assign mret_o      = live & mret_i & ~raise_exc_o;
    assign irq_ack_o   = live & irq_pending_i & ~jump_i & ~mret_i & ~raise_exc_o & ~is_store;
    assign tag_inc     = jump_o | raise_exc_o | mret_o | irq_ack_o;
    assign curr_tag_o  = curr_tag;

    always_comb begin
        load_shift = load_data_i >> {result1_i[1:0], 3'b000};
        case (funct3_i)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {24'd0, load_shift[7:0]};
            3'b101:  load_ext = {16'd0, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    assign wr_data_o = load_i ? load_ext : result0_i;

    // Head is hidden while reset is held so a pending handshake is abandoned.
    assign head_vis    = ~empty & ~reset;
    assign mem_req_o   = head_vis;
    assign mem_addr_o  = head_vis ? addr_mem[rd_ptr] : 32'd0;
    assign mem_wdata_o = head_vis ? data_mem[rd_ptr] : 32'd0;
    assign mem_be_o    = head_vis ? be_mem[rd_ptr]   : 4'd0;
    assign sb_empty_o  = empty | reset;

    assign push = live & is_store & ~raise_exc_o;
    assign pop  = head_vis & mem_gnt_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            curr_tag <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (tag_inc) curr_tag <= curr_tag + TAG_W'(1);
            if (push)    wr_ptr   <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr   <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= result1_i;
            data_mem[wr_ptr] <= result0_i;
            be_mem[wr_ptr]   <= we_mem_i;
        end
    end

endmodule
